// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier:
// state encoding, default widths and the product negate helper.
package mult_pkg;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 6;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        FIN   = 2'd3
    } stateT;

    // Two's complement of a full-width product, used to restore the sign
    // after multiplying magnitudes.
    function automatic logic [PROD_W-1:0] negProd(input logic [PROD_W-1:0] v);
        return (~v) + PROD_W'(1);
    endfunction

endpackage

// File: rtl/mult32_seq_if.sv
// Request/response bundle between the ALU sequencer and the multiplier.
// The master issues START with operands; the slave answers with
// BUSY/DONE and the HI/LO product halves.
interface mult32_seq_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, SIGNED, A, B,
        input  BUSY, DONE, HI, LO
    );

    modport slave (
        input  START, SIGNED, A, B,
        output BUSY, DONE, HI, LO
    );
endinterface

// File: rtl/mult32_seq_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into
// the accumulator, then shift {carry, acc, mplier} right by one so the
// retired multiplier bit falls off and the product's low half fills in.
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mplier,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] mplierNext
);

    logic [WIDTH:0] sum;

    // Add with a carry bit so the shift never loses the top of the sum.
    always_comb begin
        sum = {1'b0, acc};
        if (mplier[0]) begin
            sum = {1'b0, acc} + {1'b0, mcand};
        end
        accNext    = sum[WIDTH:1];
        mplierNext = {sum[0], mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult32_seq.sv
// Iterative signed/unsigned multiplier retiring one multiplier bit per
// clock. Magnitudes are multiplied and the sign is restored in FIXUP,
// so the most negative operand needs no special handling.
// WIDTH must match mult_pkg::WIDTH because the negate helper is sized there.
module mult32_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH,
    parameter int CNT_W = mult_pkg::CNT_W
) (
    input  logic        CLK,
    input  logic        RST,
    mult32_seq_if.slave bus
);

    stateT             state;
    stateT             stateNext;
    logic              accept;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  accStep;
    logic [WIDTH-1:0]  mplierStep;
    logic              neg;
    logic [CNT_W-1:0]  cnt;
    logic [2*WIDTH-1:0] prodFixed;
    logic              busyReg;
    logic              doneReg;
    logic [WIDTH-1:0]  hiReg;
    logic [WIDTH-1:0]  loReg;

    mult_step #(.WIDTH(WIDTH)) uStep (
        .acc        (acc),
        .mplier     (mplier),
        .mcand      (mcand),
        .accNext    (accStep),
        .mplierNext (mplierStep)
    );

    // Sequencing: a request is taken in IDLE or in FIN, which gives back-to-back operation.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        prodFixed = neg ? negProd({acc, mplier}) : {acc, mplier};
        case (state)
            IDLE: begin
                if (bus.START) begin
                    accept    = 1'b1;
                    stateNext = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    stateNext = FIXUP;
                end
            end
            FIXUP: stateNext = FIN;
            FIN: begin
                if (bus.START) begin
                    accept    = 1'b1;
                    stateNext = CALC;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath: latch operand magnitudes on accept, iterate in CALC, apply sign in FIXUP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= (bus.SIGNED && bus.A[WIDTH-1]) ? -bus.A : bus.A;
            mplier <= (bus.SIGNED && bus.B[WIDTH-1]) ? -bus.B : bus.B;
            acc    <= '0;
            neg    <= bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= accStep;
            mplier <= mplierStep;
            cnt    <= cnt + CNT_W'(1);
        end else if (state == FIXUP) begin
            {acc, mplier} <= prodFixed;
        end
    end

    // Registered handshake and result; HI/LO only move on the edge entering FIN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            busyReg <= (stateNext == CALC) || (stateNext == FIXUP);
            doneReg <= (stateNext == FIN);
            if (state == FIXUP) begin
                {hiReg, loReg} <= prodFixed;
            end
        end
    end

    assign bus.BUSY = busyReg;
    assign bus.DONE = doneReg;
    assign bus.HI   = hiReg;
    assign bus.LO   = loReg;

endmodule

// File: tb/tb_mult32_seq.sv
// Bench for mult32_seq: table of operand/product vectors through a
// scoreboard queue, plus sequences for ignored START, back-to-back
// operation and reset mid-operation.
module tb_mult32_seq;

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vecT;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    vecT  vecs[$];
    logic [63:0] sb[$];

    mult32_seq_if #(.WIDTH(32)) bus ();

    mult32_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference product: extend to 64 bits according to signedness and
    // keep the low 64 bits of the product.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive a request for one cycle starting at the current negedge.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.START  = 1'b1;
        bus.SIGNED = sgn;
        bus.A      = a;
        bus.B      = b;
    endtask

    // Wait for DONE from the cycle after START was driven; counts
    // cycles, BUSY cycles and whether HI/LO moved while busy.
    task automatic waitDone(output int cycles, output int busyCycles, output logic moved);
        logic [63:0] held;
        @(negedge CLK);
        bus.START  = 1'b0;
        bus.A      = 32'hDEAD_BEEF;
        bus.B      = 32'h1234_5678;
        cycles     = 1;
        busyCycles = 0;
        moved      = 1'b0;
        held       = {bus.HI, bus.LO};
        while (bus.DONE !== 1'b1 && cycles < 60) begin
            if (bus.BUSY === 1'b1) busyCycles++;
            if ({bus.HI, bus.LO} !== held) moved = 1'b1;
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic finishOp(input string tag, input int cycles, input int busyCycles, input logic moved);
        logic [63:0] exp;
        checkOutput({tag, " latency"}, 64'(cycles), 64'd34);
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'd33);
        checkOutput({tag, " hold during calc"}, {63'b0, moved}, 64'd0);
        checkOutput({tag, " busy at done"}, {63'b0, bus.BUSY}, 64'd0);
        if (sb.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            checkOutput({tag, " product"}, {bus.HI, bus.LO}, exp);
        end
    endtask

    task automatic runVector(input vecT v, input string tag);
        int   cyc;
        int   busyCyc;
        logic moved;
        @(negedge CLK);
        applyStimulus(v.sgn, v.a, v.b);
        sb.push_back(v.prod);
        waitDone(cyc, busyCyc, moved);
        finishOp(tag, cyc, busyCyc, moved);
        @(negedge CLK);
        checkOutput({tag, " done pulse"}, {63'b0, bus.DONE}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cyc;
        int   busyCyc;
        logic moved;
        logic sawDone;
        vecT  v;

        RST        = 1'b0;
        bus.START  = 1'b0;
        bus.SIGNED = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(negedge CLK);
        checkOutput("reset state", {bus.BUSY, bus.DONE, bus.HI, bus.LO[29:0]}, 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        vecs.push_back({1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F});
        vecs.push_back({1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001});
        vecs.push_back({1'b1, 32'hFFFF_FFFD,  32'd7,          64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back({1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001});
        vecs.push_back({1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000});
        vecs.push_back({1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000});
        vecs.push_back({1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000});
        vecs.push_back({1'b0, 32'd0,          32'h0001_2345,  64'h0});
        for (int i = 0; i < 4; i++) begin
            v.sgn  = logic'(i % 2);
            v.a    = $urandom;
            v.b    = $urandom;
            v.prod = model(v.sgn, v.a, v.b);
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // START during an operation must be ignored.
        @(negedge CLK);
        applyStimulus(1'b0, 32'd2, 32'd2);
        sb.push_back(64'd4);
        @(negedge CLK);
        bus.START = 1'b0;
        cyc = 1;
        while (bus.DONE !== 1'b1 && cyc < 60) begin
            if (cyc == 10) applyStimulus(1'b0, 32'd9, 32'd9);
            if (cyc == 11) bus.START = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        checkOutput("ignored start latency", 64'(cyc), 64'd34);
        checkOutput("ignored start product", {bus.HI, bus.LO}, sb.pop_front());

        // START held in FIN launches the next operation immediately.
        applyStimulus(1'b0, 32'd5, 32'd5);
        sb.push_back(64'd25);
        waitDone(cyc, busyCyc, moved);
        finishOp("back-to-back", cyc, busyCyc, moved);

        // Reset part-way through an operation aborts it.
        @(negedge CLK);
        applyStimulus(1'b0, 32'd100, 32'd100);
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (14) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checkOutput("reset abort outputs", {bus.BUSY, bus.DONE, bus.HI, bus.LO[29:0]}, 64'd0);
        sawDone = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) sawDone = 1'b1;
        end
        checkOutput("no done after abort", {63'b0, sawDone}, 64'd0);
        runVector({1'b0, 32'd6, 32'd7, 64'd42}, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
